// File: rtl/trace_pkg.sv
// Shared types and constants for the trace packer: default word width,
// length-field width derivation and the packer FSM states.
package trace_pkg;

  localparam int FPAY_DEFAULT = 32;

  // Wide enough to hold every length from 0 up to and including fpay.
  function automatic int calc_lw(input int fpay);
    return $clog2(fpay + 1);
  endfunction

  typedef enum logic {
    IDLE,
    FLUSH_PEND
  } state_t;

endpackage

// File: rtl/trace_bit_aligner.sv
// Masks a sample down to its valid LSBs and shifts it up to the current
// fill position inside a double-width window.
module trace_bit_aligner
  import trace_pkg::*;
#(
  parameter int Fpay = FPAY_DEFAULT,
  parameter int LW   = calc_lw(Fpay)
) (
  input  logic [Fpay-1:0]   sample,
  input  logic [LW-1:0]     len,
  input  logic [LW-1:0]     fill,
  output logic [2*Fpay-1:0] aligned
);

  localparam logic [2*Fpay-1:0] ONE = {{(2*Fpay-1){1'b0}}, 1'b1};

  logic [2*Fpay-1:0] mask;

  // The window is double width so a sample straddling the word boundary
  // keeps its upper part for the next word instead of losing it.
  always_comb begin
    mask    = (ONE << len) - ONE;
    aligned = ({{Fpay{1'b0}}, sample} & mask) << fill;
  end

endmodule

// File: rtl/trace_packer.sv
// Packs variable-length trace samples LSB-first into dense Fpay-bit words,
// with explicit flush of a partial word and a saturating word counter.
module trace_packer
  import trace_pkg::*;
#(
  parameter int Fpay = FPAY_DEFAULT,
  parameter int LW   = calc_lw(Fpay),
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trigger,
  input  logic [LW-1:0]   trigger_length,
  input  logic [Fpay-1:0] trace_signal_in,
  input  logic            flush,
  output logic            wr_en,
  output logic [Fpay-1:0] dout,
  output logic [LW-1:0]   fill_level,
  output logic            busy,
  output logic            drop,
  output logic            len_err,
  output logic [CW-1:0]   word_count
);

  localparam int SW = LW + 1;

  state_t            state, state_n;
  logic [Fpay-1:0]   acc, acc_n;
  logic [LW-1:0]     fill_n;
  logic              wr_en_n, len_err_n, drop_n;
  logic [Fpay-1:0]   dout_n;
  logic [CW-1:0]     word_count_n;

  logic              take, over_len;
  logic [LW-1:0]     len_clamped, len_use;
  logic [SW-1:0]     sum;
  logic [2*Fpay-1:0] aligned, combined;

  always_comb begin
    over_len    = SW'(trigger_length) > SW'(Fpay);
    len_clamped = over_len ? LW'(Fpay) : trigger_length;
    take        = (state == IDLE) && trigger && (trigger_length != '0);
    // A zero length makes the aligner contribute nothing, so flush-only
    // cycles reuse the same append path.
    len_use     = take ? len_clamped : '0;
    sum         = SW'(fill_level) + SW'(len_use);
  end

  trace_bit_aligner #(
    .Fpay (Fpay),
    .LW   (LW)
  ) u_aligner (
    .sample  (trace_signal_in),
    .len     (len_use),
    .fill    (fill_level),
    .aligned (aligned)
  );

  assign combined = {{Fpay{1'b0}}, acc} | aligned;
  assign busy     = (state == FLUSH_PEND);

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    fill_n    = fill_level;
    wr_en_n   = 1'b0;
    dout_n    = dout;
    len_err_n = 1'b0;
    drop_n    = 1'b0;

    case (state)
      IDLE: begin
        len_err_n = take && over_len;
        if (flush) begin
          if (sum != '0) begin
            wr_en_n = 1'b1;
            dout_n  = combined[Fpay-1:0];
            if (sum > SW'(Fpay)) begin
              acc_n   = combined[2*Fpay-1:Fpay];
              fill_n  = LW'(sum - SW'(Fpay));
              state_n = FLUSH_PEND;
            end else begin
              acc_n  = '0;
              fill_n = '0;
            end
          end
        end else if (take) begin
          if (sum >= SW'(Fpay)) begin
            wr_en_n = 1'b1;
            dout_n  = combined[Fpay-1:0];
            acc_n   = combined[2*Fpay-1:Fpay];
            fill_n  = LW'(sum - SW'(Fpay));
          end else begin
            acc_n  = combined[Fpay-1:0];
            fill_n = LW'(sum);
          end
        end
      end

      FLUSH_PEND: begin
        wr_en_n = 1'b1;
        dout_n  = acc;
        acc_n   = '0;
        fill_n  = '0;
        drop_n  = trigger;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    word_count_n = (wr_en_n && (word_count != '1)) ? word_count + 1'b1 : word_count;
  end

  // NOTE: non-blocking assignments so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      fill_level <= '0;
      wr_en      <= 1'b0;
      dout       <= '0;
      len_err    <= 1'b0;
      drop       <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      fill_level <= fill_n;
      wr_en      <= wr_en_n;
      dout       <= dout_n;
      len_err    <= len_err_n;
      drop       <= drop_n;
      word_count <= word_count_n;
    end
  end

endmodule

// File: tb/tb_trace_packer.sv
// Directed bench for trace_packer: packing, straddling, flush, busy/drop,
// length edges, mid-word reset and counter saturation on a narrow instance.
module tb_trace_packer;

  localparam int FPAY = 32;
  localparam int LW   = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            trigger;
  logic [LW-1:0]   trigger_length;
  logic [FPAY-1:0] trace_signal_in;
  logic            flush;

  logic            wr_en, busy, drop, len_err;
  logic [FPAY-1:0] dout;
  logic [LW-1:0]   fill_level;
  logic [15:0]     word_count;

  logic            s_wr_en, s_busy, s_drop, s_len_err;
  logic [FPAY-1:0] s_dout;
  logic [LW-1:0]   s_fill_level;
  logic [3:0]      s_word_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trace_packer #(.Fpay(FPAY), .CW(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .trigger         (trigger),
    .trigger_length  (trigger_length),
    .trace_signal_in (trace_signal_in),
    .flush           (flush),
    .wr_en           (wr_en),
    .dout            (dout),
    .fill_level      (fill_level),
    .busy            (busy),
    .drop            (drop),
    .len_err         (len_err),
    .word_count      (word_count)
  );

  trace_packer #(.Fpay(FPAY), .CW(4)) dut_sat (
    .clk             (clk),
    .reset           (reset),
    .trigger         (trigger),
    .trigger_length  (trigger_length),
    .trace_signal_in (trace_signal_in),
    .flush           (flush),
    .wr_en           (s_wr_en),
    .dout            (s_dout),
    .fill_level      (s_fill_level),
    .busy            (s_busy),
    .drop            (s_drop),
    .len_err         (s_len_err),
    .word_count      (s_word_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic trig, input logic [LW-1:0] len,
                       input logic [FPAY-1:0] data, input logic fl);
    trigger         = trig;
    trigger_length  = len;
    trace_signal_in = data;
    flush           = fl;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle_in();

    // Reset and idle
    repeat (3) cyc();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    reset = 1'b0;
    repeat (2) begin
      cyc();
      check("idle_wr_en", 64'(wr_en), 64'd0);
      check("idle_dout", 64'(dout), 64'd0);
      check("idle_fill", 64'(fill_level), 64'd0);
      check("idle_wc", 64'(word_count), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Four full bytes
    drive(1'b1, 6'd8, 32'h11, 1'b0); cyc();
    drive(1'b1, 6'd8, 32'h22, 1'b0); cyc();
    drive(1'b1, 6'd8, 32'h33, 1'b0); cyc();
    check("bytes_fill24", 64'(fill_level), 64'd24);
    check("bytes_no_wr", 64'(wr_en), 64'd0);
    drive(1'b1, 6'd8, 32'h44, 1'b0); cyc();
    idle_in();
    check("bytes_wr_en", 64'(wr_en), 64'd1);
    check("bytes_dout", 64'(dout), 64'h44332211);
    check("bytes_fill", 64'(fill_level), 64'd0);
    check("bytes_wc", 64'(word_count), 64'd1);
    cyc();
    check("bytes_pulse", 64'(wr_en), 64'd0);

    // Straddle then flush
    drive(1'b1, 6'd20, 32'hABCDE, 1'b0); cyc();
    check("str_fill20", 64'(fill_level), 64'd20);
    drive(1'b1, 6'd20, 32'h12345, 1'b0); cyc();
    idle_in();
    check("str_wr_en", 64'(wr_en), 64'd1);
    check("str_dout", 64'(dout), 64'h345ABCDE);
    check("str_fill", 64'(fill_level), 64'd8);
    flush = 1'b1; cyc();
    check("fl_wr_en", 64'(wr_en), 64'd1);
    check("fl_dout", 64'(dout), 64'h00000012);
    check("fl_fill", 64'(fill_level), 64'd0);
    check("fl_wc", 64'(word_count), 64'd3);
    cyc();
    flush = 1'b0;
    check("fl2_no_wr", 64'(wr_en), 64'd0);

    // Simultaneous trigger and flush overflowing into FLUSH_PEND
    drive(1'b1, 6'd28, 32'h0000001, 1'b0); cyc();
    check("pre_fill28", 64'(fill_level), 64'd28);
    drive(1'b1, 6'd8, 32'hAB, 1'b1); cyc();
    drive(1'b1, 6'd8, 32'h55, 1'b0);
    check("tf_wr_en", 64'(wr_en), 64'd1);
    check("tf_dout", 64'(dout), 64'hB0000001);
    check("tf_busy", 64'(busy), 64'd1);
    cyc();
    idle_in();
    check("res_wr_en", 64'(wr_en), 64'd1);
    check("res_dout", 64'(dout), 64'h0000000A);
    check("res_drop", 64'(drop), 64'd1);
    check("res_fill", 64'(fill_level), 64'd0);
    check("res_busy", 64'(busy), 64'd0);
    check("res_wc", 64'(word_count), 64'd5);
    cyc();
    check("drop_pulse", 64'(drop), 64'd0);
    check("res_pulse", 64'(wr_en), 64'd0);

    // Length edges
    drive(1'b1, 6'd0, 32'hFFFFFFFF, 1'b0); cyc();
    check("l0_wr_en", 64'(wr_en), 64'd0);
    check("l0_fill", 64'(fill_level), 64'd0);
    check("l0_len_err", 64'(len_err), 64'd0);
    drive(1'b1, 6'd40, 32'hDEADBEEF, 1'b0); cyc();
    check("l40_len_err", 64'(len_err), 64'd1);
    check("l40_wr_en", 64'(wr_en), 64'd1);
    check("l40_dout", 64'(dout), 64'hDEADBEEF);
    check("l40_fill", 64'(fill_level), 64'd0);
    drive(1'b1, 6'd4, 32'hFFFFFFFF, 1'b0); cyc();
    check("l4_fill", 64'(fill_level), 64'd4);
    check("l4_len_err", 64'(len_err), 64'd0);
    drive(1'b0, '0, '0, 1'b1); cyc();
    idle_in();
    check("mask_wr_en", 64'(wr_en), 64'd1);
    check("mask_dout", 64'(dout), 64'h0000000F);
    check("mask_wc", 64'(word_count), 64'd7);

    // Reset mid-word
    drive(1'b1, 6'd12, 32'hABC, 1'b0); cyc();
    idle_in();
    check("mid_fill12", 64'(fill_level), 64'd12);
    reset = 1'b1; cyc();
    reset = 1'b0;
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_wr", 64'(wr_en), 64'd0);
    check("mid_rst_wc", 64'(word_count), 64'd0);
    cyc();
    check("mid_post_wr", 64'(wr_en), 64'd0);

    // Saturation: 20 full words; the CW=4 instance must stop at 15
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 6'd32, 32'hC0DE0000 + 32'(i), 1'b0);
      cyc();
    end
    idle_in();
    check("sat_last_dout", 64'(dout), 64'hC0DE0014);
    check("sat_wc16", 64'(word_count), 64'd20);
    check("sat_wc4", 64'(s_word_count), 64'hF);
    cyc();
    check("sat_wc4_hold", 64'(s_word_count), 64'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
